trax_move_codec: RTL
====================

# trax_move_codec

Full-duplex Trax move codec between the game engine and a byte-level UART. It serialises an engine move into the ASCII line `<col letters><row digits><type>\n` and parses received ASCII lines into moves. It also captures the one-time colour byte (`W`/`B`). Column/row widths and notation lengths are parametrised. Receive and transmit run concurrently and independently.

## Interface
- COORD_W, 10, width of each coordinate field
- MAX_COL_LETTERS, 2, max column letters per line (bijective base-26)
- MAX_ROW_DIGITS, 3, max row decimal digits per line

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- game_restart  in  1  sync pulse; re-arms colour capture, flushes rx line
- tx_move  in  2*COORD_W+2  [COORD_W-1:0] row, [2*COORD_W-1:COORD_W] col, top 2 bits type (01 `+`, 10 `/`, 11 `\`)
- tx_move_valid  in  1  move offered
- tx_move_ready  out  1  codec idle, move accepted when valid&&ready
- tx_error  out  1  1-cycle pulse, accepted move unencodable
- tx_byte  out  8  ASCII byte to UART
- tx_byte_valid  out  1  tx_byte valid
- tx_byte_ready  in  1  UART takes byte when valid&&ready
- rx_byte  in  8  received byte
- rx_byte_valid  in  1  1-cycle strobe per received byte
- rx_move  out  2*COORD_W+2  last decoded move, same packing as tx_move
- rx_move_valid  out  1  1-cycle pulse, new rx_move
- rx_error  out  1  1-cycle pulse, malformed line detected
- color  out  1  0 = White, 1 = Black
- color_valid  out  1  held high once colour captured

## Operation
- Column encoding: 0 → `@` (single char). 1..26 → `A`..`Z`. 27 → `AA`, 28 → `AB`, 702 → `ZZ`. Bijective base-26, most significant letter first.
- Row encoding: decimal, no leading zeros; 0 → `0`.
- TX FSM: IDLE → COL → ROW → TYPE → NL → IDLE.
- Move acceptance latches tx_move. Move is unencodable if any of: type 00; column needs > MAX_COL_LETTERS letters; row needs > MAX_ROW_DIGITS digits. An unencodable move pulses tx_error, emits no bytes, and the FSM stays in IDLE.
- Each state emits its characters in order, one byte per transfer.
- tx_byte and tx_byte_valid are held stable until transfer.
- RX FSM: WAIT_COLOR, COL, ROW, TYPE, NL, SKIP. `\r` is ignored in every state.
- WAIT_COLOR:
  - `W` → color=0; `B` → color=1. Either sets color_valid and moves to COL.
  - All other bytes are ignored.
- COL, zero letters so far:
  - `\n` is ignored (empty line).
  - `@` sets col=0 and marks the column as closed.
  - `A`..`Z`: col = col*26 + (ch-64).
- Letter count > MAX_COL_LETTERS, or accumulator > 2^COORD_W-1 → error.
- A digit after ≥1 column char → ROW, row = digit.
- ROW: row = row*10 + digit. Count > MAX_ROW_DIGITS, or value overflow → error.
- Type char (`+`, `/`, `\`) after ≥1 digit → TYPE, type is latched.
- TYPE: `\n` → load rx_move, pulse rx_move_valid, clear accumulators, go to COL.
- Any other byte in any parse state → error.
- On error: pulse rx_error and clear accumulators. If the offending byte is `\n`, go to COL; otherwise go to SKIP.
- SKIP: discard bytes until `\n`, then go to COL.
- game_restart: color_valid=0, rx FSM → WAIT_COLOR, accumulators cleared. TX path is unaffected.

## Timing
- Reset (async, reset_n low): every output 0, both FSMs IDLE/WAIT_COLOR.
- tx_move_ready is registered. It rises on the first clock edge after reset_n release.
- Accepting clock edge: tx_move_ready falls. First byte is valid the next cycle.
- Back-to-back transfers: a new byte is presented the cycle after each transfer. Throughput is 1 byte/cycle when tx_byte_ready is held high.
- tx_move_ready rises the cycle after the `\n` transfer. For an unencodable move, it rises the cycle after tx_error.
- rx_move_valid and rx_error are registered. They assert the cycle after the triggering rx_byte_valid strobe.
- rx_move holds its value until the next rx_move_valid.
- color and color_valid update the cycle after the colour byte.
- game_restart and rx_byte_valid in the same cycle: game_restart wins and the byte is dropped.
- reset_n assertion mid-line aborts both paths immediately. After release, the next move is sent from its first character.

## Test plan
- tx col=28 row=5 type=10, tx_byte_ready=1 → bytes 0x41 0x42 0x35 0x2F 0x0A on 5 consecutive cycles; tx_move_ready low throughout, high the cycle after 0x0A.
- tx col=0 row=0 type=01; tx_byte_ready low 3 cycles during byte 2 → sequence `@0+\n`; byte 0x30 stable while stalled.
- rx `B\n` then `Z12\\n` → color=1, color_valid=1; one rx_move_valid with col=26, row=12, type=11.
- rx `ABC1+\n` → rx_error the cycle after `C`, no rx_move_valid. Then rx `A1+\n` → col=1, row=1, type=01. Also rx `AB1234/\n` → rx_error on 4th digit.
- tx col=703 (needs 3 letters) → tx_error pulse, no tx_byte_valid, tx_move_ready back high next cycle. tx type=00 → same response.
- reset_n low after 2 bytes of `AB5/\n` → tx_byte_valid 0 immediately; after release, same move re-sent from 0x41. game_restart mid-rx-line → color_valid=0; next `W` → color=0.

Source files
------------

// File: rtl/trax_move_codec.sv
// Trax move codec: serialises engine moves into ASCII notation lines and parses
// received lines back into moves. TX and RX run independently; RX also latches the colour.
module trax_move_codec #(
    parameter int unsigned COORD_W         = 10,
    parameter int unsigned MAX_COL_LETTERS = 2,
    parameter int unsigned MAX_ROW_DIGITS  = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 game_restart,
    input  logic [2*COORD_W+1:0] tx_move,
    input  logic                 tx_move_valid,
    output logic                 tx_move_ready,
    output logic                 tx_error,
    output logic [7:0]           tx_byte,
    output logic                 tx_byte_valid,
    input  logic                 tx_byte_ready,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_byte_valid,
    output logic [2*COORD_W+1:0] rx_move,
    output logic                 rx_move_valid,
    output logic                 rx_error,
    output logic                 color,
    output logic                 color_valid
);

    localparam int unsigned MW  = 2 * COORD_W + 2;
    localparam int unsigned CLW = $clog2(MAX_COL_LETTERS + 1);
    localparam int unsigned RLW = $clog2(MAX_ROW_DIGITS + 1);
    localparam int unsigned CAW = COORD_W + 5;
    localparam int unsigned RAW = COORD_W + 4;

    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] RADIX_COL = COORD_W'(26);
    localparam logic [COORD_W-1:0] RADIX_ROW = COORD_W'(10);

    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_A      = 8'h41;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_SLASH  = 8'h2F;
    localparam logic [7:0] CH_BSLASH = 8'h5C;
    localparam logic [7:0] CH_W      = 8'h57;
    localparam logic [7:0] CH_B      = 8'h42;

    // ---------------------------------------------------------------- TX path
    typedef enum logic [2:0] {TxIdle, TxCol, TxRow, TxType, TxNl} tx_state_t;

    tx_state_t          tx_state_q, tx_state_d;
    logic [7:0]         col_buf_q [MAX_COL_LETTERS];
    logic [7:0]         col_buf_d [MAX_COL_LETTERS];
    logic [7:0]         row_buf_q [MAX_ROW_DIGITS];
    logic [7:0]         row_buf_d [MAX_ROW_DIGITS];
    logic [CLW-1:0]     col_left_q, col_left_d;
    logic [RLW-1:0]     row_left_q, row_left_d;
    logic [7:0]         type_ch_q, type_ch_d;
    logic               tx_ready_q, tx_ready_d;
    logic               tx_error_q, tx_error_d;

    logic [7:0]         enc_col [MAX_COL_LETTERS];
    logic [7:0]         enc_row [MAX_ROW_DIGITS];
    logic [CLW-1:0]     enc_col_len;
    logic [RLW-1:0]     enc_row_len;
    logic [7:0]         enc_type;
    logic               enc_bad;
    logic [COORD_W-1:0] cn, rn;
    logic [1:0]         tx_type_in;
    logic               tx_accept, tx_xfer;

    assign tx_type_in = tx_move[MW-1:MW-2];
    assign tx_accept  = tx_move_valid && tx_ready_q;
    assign tx_xfer    = tx_byte_valid && tx_byte_ready;

    // Digits are produced least significant first and shifted in at index 0,
    // so index 0 ends up holding the most significant character.
    always_comb begin
        cn          = tx_move[2*COORD_W-1:COORD_W];
        rn          = tx_move[COORD_W-1:0];
        enc_col_len = '0;
        enc_row_len = '0;
        for (int i = 0; i < MAX_COL_LETTERS; i++) enc_col[i] = CH_AT;
        for (int i = 0; i < MAX_ROW_DIGITS; i++) enc_row[i] = CH_ZERO;
        if (cn == '0) begin
            enc_col_len = CLW'(1);
        end else begin
            for (int i = 0; i < MAX_COL_LETTERS; i++) begin
                if (cn != '0) begin
                    cn = cn - C_ONE;
                    for (int j = MAX_COL_LETTERS - 1; j > 0; j--) enc_col[j] = enc_col[j-1];
                    enc_col[0]  = CH_A + 8'(cn % RADIX_COL);
                    cn          = cn / RADIX_COL;
                    enc_col_len = CLW'(i + 1);
                end
            end
        end
        for (int i = 0; i < MAX_ROW_DIGITS; i++) begin
            if (rn != '0 || i == 0) begin
                for (int j = MAX_ROW_DIGITS - 1; j > 0; j--) enc_row[j] = enc_row[j-1];
                enc_row[0]  = CH_ZERO + 8'(rn % RADIX_ROW);
                rn          = rn / RADIX_ROW;
                enc_row_len = RLW'(i + 1);
            end
        end
        case (tx_type_in)
            2'b01:   enc_type = CH_PLUS;
            2'b10:   enc_type = CH_SLASH;
            2'b11:   enc_type = CH_BSLASH;
            default: enc_type = 8'h00;
        endcase
        // Leftover quotient means more characters than the line format allows.
        enc_bad = (tx_type_in == 2'b00) || (cn != '0) || (rn != '0);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        col_buf_d  = col_buf_q;
        row_buf_d  = row_buf_q;
        col_left_d = col_left_q;
        row_left_d = row_left_q;
        type_ch_d  = type_ch_q;
        tx_ready_d = 1'b0;
        tx_error_d = 1'b0;
        case (tx_state_q)
            TxIdle: begin
                if (tx_accept) begin
                    if (enc_bad) begin
                        tx_error_d = 1'b1;
                    end else begin
                        col_buf_d  = enc_col;
                        row_buf_d  = enc_row;
                        col_left_d = enc_col_len;
                        row_left_d = enc_row_len;
                        type_ch_d  = enc_type;
                        tx_state_d = TxCol;
                    end
                end else begin
                    tx_ready_d = 1'b1;
                end
            end
            TxCol: begin
                if (tx_xfer) begin
                    if (col_left_q == CLW'(1)) begin
                        tx_state_d = TxRow;
                    end else begin
                        for (int j = 0; j < MAX_COL_LETTERS - 1; j++) col_buf_d[j] = col_buf_q[j+1];
                        col_left_d = col_left_q - CLW'(1);
                    end
                end
            end
            TxRow: begin
                if (tx_xfer) begin
                    if (row_left_q == RLW'(1)) begin
                        tx_state_d = TxType;
                    end else begin
                        for (int j = 0; j < MAX_ROW_DIGITS - 1; j++) row_buf_d[j] = row_buf_q[j+1];
                        row_left_d = row_left_q - RLW'(1);
                    end
                end
            end
            TxType: begin
                if (tx_xfer) tx_state_d = TxNl;
            end
            TxNl: begin
                if (tx_xfer) begin
                    tx_state_d = TxIdle;
                    tx_ready_d = 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TxIdle;
            col_left_q <= '0;
            row_left_q <= '0;
            type_ch_q  <= '0;
            tx_ready_q <= 1'b0;
            tx_error_q <= 1'b0;
            for (int i = 0; i < MAX_COL_LETTERS; i++) col_buf_q[i] <= '0;
            for (int i = 0; i < MAX_ROW_DIGITS; i++) row_buf_q[i] <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            col_left_q <= col_left_d;
            row_left_q <= row_left_d;
            type_ch_q  <= type_ch_d;
            tx_ready_q <= tx_ready_d;
            tx_error_q <= tx_error_d;
            col_buf_q  <= col_buf_d;
            row_buf_q  <= row_buf_d;
        end
    end

    always_comb begin
        case (tx_state_q)
            TxCol:   tx_byte = col_buf_q[0];
            TxRow:   tx_byte = row_buf_q[0];
            TxType:  tx_byte = type_ch_q;
            TxNl:    tx_byte = CH_NL;
            default: tx_byte = 8'h00;
        endcase
    end

    assign tx_byte_valid = (tx_state_q != TxIdle);
    assign tx_move_ready = tx_ready_q;
    assign tx_error      = tx_error_q;

    // ---------------------------------------------------------------- RX path
    typedef enum logic [2:0] {RxWaitColor, RxCol, RxRow, RxType, RxSkip} rx_state_t;

    rx_state_t          rx_state_q, rx_state_d;
    logic [COORD_W-1:0] rcol_q, rcol_d, rrow_q, rrow_d;
    logic [CLW-1:0]     rcol_cnt_q, rcol_cnt_d;
    logic [RLW-1:0]     rrow_cnt_q, rrow_cnt_d;
    logic               rcol_closed_q, rcol_closed_d;
    logic [1:0]         rtype_q, rtype_d;
    logic [MW-1:0]      rx_move_q, rx_move_d;
    logic               rx_move_valid_q, rx_move_valid_d;
    logic               rx_error_q, rx_error_d;
    logic               color_q, color_d, color_valid_q, color_valid_d;

    logic               rx_is_letter, rx_is_digit, rx_is_type, col_any, rx_err;
    logic [1:0]         rx_type_code;
    logic [CAW-1:0]     col_next;
    logic [RAW-1:0]     row_next;

    always_comb begin
        case (rx_byte)
            CH_PLUS:   rx_type_code = 2'b01;
            CH_SLASH:  rx_type_code = 2'b10;
            CH_BSLASH: rx_type_code = 2'b11;
            default:   rx_type_code = 2'b00;
        endcase
    end

    assign rx_is_type   = (rx_type_code != 2'b00);
    assign rx_is_letter = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
    assign rx_is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign col_any      = (rcol_cnt_q != '0) || rcol_closed_q;
    assign col_next     = CAW'(rcol_q) * CAW'(26) + CAW'(rx_byte - CH_AT);
    assign row_next     = RAW'(rrow_q) * RAW'(10) + RAW'(rx_byte - CH_ZERO);

    always_comb begin
        rx_state_d      = rx_state_q;
        rcol_d          = rcol_q;
        rrow_d          = rrow_q;
        rcol_cnt_d      = rcol_cnt_q;
        rrow_cnt_d      = rrow_cnt_q;
        rcol_closed_d   = rcol_closed_q;
        rtype_d         = rtype_q;
        rx_move_d       = rx_move_q;
        rx_move_valid_d = 1'b0;
        rx_error_d      = 1'b0;
        color_d         = color_q;
        color_valid_d   = color_valid_q;
        rx_err          = 1'b0;
        if (game_restart) begin
            rx_state_d    = RxWaitColor;
            color_valid_d = 1'b0;
            rcol_d        = '0;
            rrow_d        = '0;
            rcol_cnt_d    = '0;
            rrow_cnt_d    = '0;
            rcol_closed_d = 1'b0;
            rtype_d       = '0;
        end else if (rx_byte_valid && rx_byte != CH_CR) begin
            case (rx_state_q)
                RxWaitColor: begin
                    if (rx_byte == CH_W || rx_byte == CH_B) begin
                        color_d       = (rx_byte == CH_B);
                        color_valid_d = 1'b1;
                        rx_state_d    = RxCol;
                    end
                end
                RxCol: begin
                    if (rx_is_letter && !rcol_closed_q) begin
                        if (rcol_cnt_q == CLW'(MAX_COL_LETTERS) ||
                            col_next[CAW-1:COORD_W] != '0) begin
                            rx_err = 1'b1;
                        end else begin
                            rcol_d     = col_next[COORD_W-1:0];
                            rcol_cnt_d = rcol_cnt_q + CLW'(1);
                        end
                    end else if (rx_byte == CH_AT && !col_any) begin
                        rcol_d        = '0;
                        rcol_closed_d = 1'b1;
                    end else if (rx_is_digit && col_any) begin
                        rrow_d     = COORD_W'(rx_byte - CH_ZERO);
                        rrow_cnt_d = RLW'(1);
                        rx_state_d = RxRow;
                    end else if (rx_byte != CH_NL || col_any) begin
                        // A bare newline before any column char is just an empty line.
                        rx_err = 1'b1;
                    end
                end
                RxRow: begin
                    if (rx_is_digit) begin
                        if (rrow_cnt_q == RLW'(MAX_ROW_DIGITS) ||
                            row_next[RAW-1:COORD_W] != '0) begin
                            rx_err = 1'b1;
                        end else begin
                            rrow_d     = row_next[COORD_W-1:0];
                            rrow_cnt_d = rrow_cnt_q + RLW'(1);
                        end
                    end else if (rx_is_type) begin
                        rtype_d    = rx_type_code;
                        rx_state_d = RxType;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
                RxType: begin
                    if (rx_byte == CH_NL) begin
                        rx_move_d       = {rtype_q, rcol_q, rrow_q};
                        rx_move_valid_d = 1'b1;
                        rcol_d          = '0;
                        rrow_d          = '0;
                        rcol_cnt_d      = '0;
                        rrow_cnt_d      = '0;
                        rcol_closed_d   = 1'b0;
                        rtype_d         = '0;
                        rx_state_d      = RxCol;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
                RxSkip: begin
                    if (rx_byte == CH_NL) rx_state_d = RxCol;
                end
                default: rx_state_d = RxWaitColor;
            endcase
            if (rx_err) begin
                rx_error_d    = 1'b1;
                rcol_d        = '0;
                rrow_d        = '0;
                rcol_cnt_d    = '0;
                rrow_cnt_d    = '0;
                rcol_closed_d = 1'b0;
                rtype_d       = '0;
                rx_state_d    = (rx_byte == CH_NL) ? RxCol : RxSkip;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q      <= RxWaitColor;
            rcol_q          <= '0;
            rrow_q          <= '0;
            rcol_cnt_q      <= '0;
            rrow_cnt_q      <= '0;
            rcol_closed_q   <= 1'b0;
            rtype_q         <= '0;
            rx_move_q       <= '0;
            rx_move_valid_q <= 1'b0;
            rx_error_q      <= 1'b0;
            color_q         <= 1'b0;
            color_valid_q   <= 1'b0;
        end else begin
            rx_state_q      <= rx_state_d;
            rcol_q          <= rcol_d;
            rrow_q          <= rrow_d;
            rcol_cnt_q      <= rcol_cnt_d;
            rrow_cnt_q      <= rrow_cnt_d;
            rcol_closed_q   <= rcol_closed_d;
            rtype_q         <= rtype_d;
            rx_move_q       <= rx_move_d;
            rx_move_valid_q <= rx_move_valid_d;
            rx_error_q      <= rx_error_d;
            color_q         <= color_d;
            color_valid_q   <= color_valid_d;
        end
    end

    assign rx_move       = rx_move_q;
    assign rx_move_valid = rx_move_valid_q;
    assign rx_error      = rx_error_q;
    assign color         = color_q;
    assign color_valid   = color_valid_q;

endmodule
